layer_compositor: RTL and testbench

Parametrised, pipelined pixel compositor for the VGA path, sitting between the sprite/tile pixel generators and the VGA output pins. It merges NUM_LAYERS pixel streams by fixed priority, fills transparent pixels with the HUD/background scheme, and applies frame-synchronous screen effects (damage flash, fade-to-black for game over). All outputs are registered, with a fixed latency of two cycles.

---
 rtl/layer_compositor.sv | 189 ++++++++++++++++++
 tb/tb_layer_compositor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: fixed-priority layer merge with HUD/background fill,
// followed by frame-synchronous screen effects (flash, fade-to-black).
module layer_compositor #(
  parameter int                 NUM_LAYERS   = 16,
  parameter int                 COLOR_W      = 12,
  parameter int                 HUD_ROWS     = 20,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 12'hFDA,
  parameter int                 FLASH_FRAMES = 8,
  parameter int                 FADE_STEP    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  input  logic [9:0]                    v_cnt,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pix,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic                          frame_start,
  input  logic                          flash_req,
  input  logic                          fade_req,
  input  logic                          fade_clr,
  output logic [COLOR_W-1:0]            rgb_out,
  output logic                          valid_out,
  output logic                          fx_busy
);

  localparam int              CH_W       = COLOR_W / 3;
  localparam logic [CH_W-1:0] CH_MAX     = '1;
  localparam logic [9:0]      HUD_LAST   = 10'(HUD_ROWS);
  localparam logic [7:0]      FLASH_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0]      STEP_LAST  = 8'(FADE_STEP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLASH,
    S_FADE,
    S_BLACK
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         flash_cnt_q, flash_cnt_d;
  logic [7:0]         step_q, step_d;
  logic [CH_W-1:0]    level_q, level_d;
  logic               flash_pend_q, flash_pend_d;
  logic               fade_pend_q, fade_pend_d;
  logic               clr_pend_q, clr_pend_d;
  logic               busy_q, busy_d;

  logic [COLOR_W-1:0] pix1_q, pix1_d;
  logic               vld1_q;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               vld2_q;
  logic               found;

  // Stage 1: lowest enabled index with a nonzero pixel wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pix1_d = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (!found && layer_en[k] && (layer_pix[k*COLOR_W +: COLOR_W] != '0)) begin
        pix1_d = layer_pix[k*COLOR_W +: COLOR_W];
        found  = 1'b1;
      end
    end
    if (!found) begin
      pix1_d = (v_cnt < HUD_LAST) ? '0 : BG_COLOR;
    end
    if (!valid_in) begin
      pix1_d = '0;
    end
  end

  // Stage 2: effect is chosen from the FSM state at the moment the pixel enters.
  always_comb begin
    rgb_d = pix1_q;
    case (state_q)
      S_FLASH: if (!flash_cnt_q[0]) rgb_d = ~pix1_q;
      S_FADE: begin
        for (int c = 0; c < 3; c++) begin
          rgb_d[c*CH_W +: CH_W] = (pix1_q[c*CH_W +: CH_W] > level_q)
                                  ? pix1_q[c*CH_W +: CH_W] - level_q : '0;
        end
      end
      S_BLACK: rgb_d = '0;
      default: rgb_d = pix1_q;
    endcase
    if (!vld1_q) begin
      rgb_d = '0;
    end
  end

  // Requests latch on any cycle; the state only moves on frame_start so a frame never tears.
  always_comb begin
    state_d      = state_q;
    flash_cnt_d  = flash_cnt_q;
    step_d       = step_q;
    level_d      = level_q;
    flash_pend_d = flash_pend_q | (flash_req & ((state_q == S_IDLE) || (state_q == S_FLASH)));
    fade_pend_d  = fade_pend_q | fade_req;
    clr_pend_d   = clr_pend_q | fade_clr;

    if (frame_start) begin
      case (state_q)
        S_IDLE, S_FLASH: begin
          // A clear has nothing to undo outside FADE/BLACK, so it is dropped here.
          clr_pend_d = 1'b0;
          if (fade_pend_d) begin
            state_d      = S_FADE;
            level_d      = CH_W'(1);
            step_d       = '0;
            flash_cnt_d  = '0;
            fade_pend_d  = 1'b0;
            flash_pend_d = 1'b0;
          end else if (state_q == S_IDLE) begin
            if (flash_pend_d) begin
              state_d      = S_FLASH;
              flash_cnt_d  = '0;
              flash_pend_d = 1'b0;
            end
          end else if (flash_cnt_q == FLASH_LAST) begin
            state_d     = S_IDLE;
            flash_cnt_d = '0;
          end else begin
            flash_cnt_d = flash_cnt_q + 8'd1;
          end
        end
        S_FADE, S_BLACK: begin
          if (clr_pend_d) begin
            state_d      = S_IDLE;
            level_d      = '0;
            step_d       = '0;
            flash_pend_d = 1'b0;
            fade_pend_d  = 1'b0;
            clr_pend_d   = 1'b0;
          end else if (state_q == S_FADE) begin
            if (step_q == STEP_LAST) begin
              step_d  = '0;
              level_d = level_q + 1'b1;
              if (level_d == CH_MAX) begin
                state_d = S_BLACK;
              end
            end else begin
              step_d = step_q + 8'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE) | flash_pend_d | fade_pend_d | clr_pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      flash_cnt_q  <= '0;
      step_q       <= '0;
      level_q      <= '0;
      flash_pend_q <= 1'b0;
      fade_pend_q  <= 1'b0;
      clr_pend_q   <= 1'b0;
      busy_q       <= 1'b0;
      pix1_q       <= '0;
      vld1_q       <= 1'b0;
      rgb_q        <= '0;
      vld2_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, keeping the pipeline aligned.
      state_q      <= state_d;
      flash_cnt_q  <= flash_cnt_d;
      step_q       <= step_d;
      level_q      <= level_d;
      flash_pend_q <= flash_pend_d;
      fade_pend_q  <= fade_pend_d;
      clr_pend_q   <= clr_pend_d;
      busy_q       <= busy_d;
      pix1_q       <= pix1_d;
      vld1_q       <= valid_in;
      rgb_q        <= rgb_d;
      vld2_q       <= vld1_q;
    end
  end

  assign rgb_out   = rgb_q;
  assign valid_out = vld2_q;
  assign fx_busy   = busy_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: table of priority/background vectors plus effect
// sequences, with expected pixels queued at drive time and compared two cycles later.
module tb_layer_compositor;

  localparam int NL = 16;
  localparam int CW = 12;
  localparam int PW = NL * CW;
  localparam int FADE_STEP_TB = 2;
  localparam int LEVEL_MAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [9:0]    v_cnt = '0;
  logic [PW-1:0] layer_pix = '0;
  logic [NL-1:0] layer_en = '0;
  logic          frame_start = 1'b0;
  logic          flash_req = 1'b0;
  logic          fade_req = 1'b0;
  logic          fade_clr = 1'b0;
  logic [CW-1:0] rgb_out;
  logic          valid_out;
  logic          fx_busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string         name;
    logic          valid;
    logic [9:0]    vc;
    logic [PW-1:0] pix;
    logic [NL-1:0] en;
    logic          fs;
    logic          fl;
    logic          fd;
    logic          cl;
    logic          chk;
    logic [CW-1:0] exp;
  } rec_t;

  rec_t sb_q[$];

  layer_compositor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .v_cnt      (v_cnt),
    .layer_pix  (layer_pix),
    .layer_en   (layer_en),
    .frame_start(frame_start),
    .flash_req  (flash_req),
    .fade_req   (fade_req),
    .fade_clr   (fade_clr),
    .rgb_out    (rgb_out),
    .valid_out  (valid_out),
    .fx_busy    (fx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] lay(input int k, input logic [CW-1:0] v);
    logic [PW-1:0] r;
    r = '0;
    r[k*CW +: CW] = v;
    return r;
  endfunction

  function automatic rec_t mk(input string name, input logic valid, input logic [9:0] vc,
                              input logic [PW-1:0] pix, input logic [NL-1:0] en,
                              input logic fs, input logic fl, input logic fd, input logic cl,
                              input logic [CW-1:0] exp);
    rec_t r;
    r.name = name; r.valid = valid; r.vc = vc; r.pix = pix; r.en = en;
    r.fs = fs; r.fl = fl; r.fd = fd; r.cl = cl; r.chk = 1'b1; r.exp = exp;
    return r;
  endfunction

  // Blanking cycle carrying control pulses; its output must be 0 with valid_out low.
  function automatic rec_t ctl(input string name, input logic fs, input logic fl,
                               input logic fd, input logic cl);
    return mk(name, 1'b0, 10'd100, '0, '1, fs, fl, fd, cl, 12'h000);
  endfunction

  function automatic rec_t px(input string name, input logic [CW-1:0] v, input logic [CW-1:0] exp);
    return mk(name, 1'b1, 10'd100, lay(0, v), '1, 1'b0, 1'b0, 1'b0, 1'b0, exp);
  endfunction

  function automatic logic [CW-1:0] satsub(input logic [CW-1:0] p, input int lvl);
    logic [CW-1:0] r;
    int ch;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      ch = int'(p[c*4 +: 4]) - lvl;
      r[c*4 +: 4] = (ch < 0) ? 4'h0 : 4'(ch);
    end
    return r;
  endfunction

  // One clock: compare the output owed by the record driven two cycles ago, then drive.
  task automatic apply(input rec_t r);
    rec_t e;
    @(negedge clk);
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      if (e.chk) check(e.name, {valid_out, rgb_out}, {e.valid, e.exp});
    end
    valid_in    = r.valid;
    v_cnt       = r.vc;
    layer_pix   = r.pix;
    layer_en    = r.en;
    frame_start = r.fs;
    flash_req   = r.fl;
    fade_req    = r.fd;
    fade_clr    = r.cl;
    sb_q.push_back(r);
  endtask

  task automatic busy_check(input string name, input logic exp);
    @(posedge clk);
    #1;
    check(name, {12'h000, fx_busy}, {12'h000, exp});
  endtask

  // From IDLE: fade request with frame_start, then frames until BLACK has held 10 frames.
  task automatic fade_run(input string tag);
    int lvl;
    for (int j = 1; j <= 39; j++) begin
      apply(ctl($sformatf("%s_fs%0d", tag, j), 1'b1, 1'b0, (j == 1), 1'b0));
      lvl = 1 + (j - 1) / FADE_STEP_TB;
      apply(px($sformatf("%s_pix%0d", tag, j), 12'hFDA,
               (lvl >= LEVEL_MAX) ? 12'h000 : satsub(12'hFDA, lvl)));
    end
  endtask

  rec_t vec[12];

  initial begin
    vec[0]  = mk("prio_l3",     1'b1, 10'd100,  lay(3, 12'h0F0) | lay(7, 12'h00F), '1, 0, 0, 0, 0, 12'h0F0);
    vec[1]  = mk("prio_l3_off", 1'b1, 10'd100,  lay(3, 12'h0F0) | lay(7, 12'h00F), ~16'h0008, 0, 0, 0, 0, 12'h00F);
    vec[2]  = mk("bg_row19",    1'b1, 10'd19,   '0, '1, 0, 0, 0, 0, 12'h000);
    vec[3]  = mk("bg_row20",    1'b1, 10'd20,   '0, '1, 0, 0, 0, 0, 12'hFDA);
    vec[4]  = mk("invalid",     1'b0, 10'd100,  lay(3, 12'h0F0), '1, 0, 0, 0, 0, 12'h000);
    vec[5]  = mk("prio_l0",     1'b1, 10'd100,  lay(0, 12'hABC) | lay(15, 12'h111), '1, 0, 0, 0, 0, 12'hABC);
    vec[6]  = mk("prio_l15",    1'b1, 10'd5,    lay(15, 12'h001), '1, 0, 0, 0, 0, 12'h001);
    vec[7]  = mk("l15_off_bg",  1'b1, 10'd500,  lay(15, 12'h001), 16'h7FFF, 0, 0, 0, 0, 12'hFDA);
    vec[8]  = mk("all_off_hud", 1'b1, 10'd0,    lay(0, 12'hFFF), '0, 0, 0, 0, 0, 12'h000);
    vec[9]  = mk("prio_l5",     1'b1, 10'd300,  lay(5, 12'h800) | lay(9, 12'h070), '1, 0, 0, 0, 0, 12'h800);
    vec[10] = mk("bg_last_row", 1'b1, 10'd1023, '0, '1, 0, 0, 0, 0, 12'hFDA);
    vec[11] = mk("l5_off",      1'b1, 10'd300,  lay(5, 12'h800) | lay(9, 12'h070), ~16'h0020, 0, 0, 0, 0, 12'h070);

    #1;
    check("reset_rgb_valid", {valid_out, rgb_out}, 13'h0000);
    check("reset_busy", {12'h000, fx_busy}, 13'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) apply(vec[i]);
    apply(ctl("drain0", 1'b0, 1'b0, 1'b0, 1'b0));
    apply(ctl("drain1", 1'b0, 1'b0, 1'b0, 1'b0));
    busy_check("idle_busy", 1'b0);

    // Flash: frames alternate inverted/plain, the ninth frame_start returns to IDLE.
    apply(ctl("flash_req", 1'b0, 1'b1, 1'b0, 1'b0));
    busy_check("flash_pending_busy", 1'b1);
    for (int f = 0; f <= 8; f++) begin
      apply(ctl($sformatf("flash_fs%0d", f), 1'b1, 1'b0, 1'b0, 1'b0));
      apply(px($sformatf("flash_f%0d", f), 12'h123,
               (f < 8 && (f % 2) == 0) ? 12'hEDC : 12'h123));
      if (f == 7) busy_check("flash_last_busy", 1'b1);
    end
    busy_check("flash_done_busy", 1'b0);

    // Fade to BLACK; a flash request in BLACK must not survive the clear.
    fade_run("fadeA");
    busy_check("black_busy", 1'b1);
    apply(ctl("black_flash_req", 1'b0, 1'b1, 1'b0, 1'b0));
    apply(ctl("black_fs", 1'b1, 1'b0, 1'b0, 1'b0));
    apply(px("black_hold", 12'hFDA, 12'h000));
    apply(ctl("clr_fs", 1'b1, 1'b0, 1'b0, 1'b1));
    apply(px("after_clr", 12'hFDA, 12'hFDA));
    apply(ctl("no_flash_fs", 1'b1, 1'b0, 1'b0, 1'b0));
    apply(px("no_flash_pix", 12'hFDA, 12'hFDA));
    busy_check("after_clr_busy", 1'b0);

    // Same-cycle flash and fade requests: fade wins.
    apply(ctl("both_req", 1'b0, 1'b1, 1'b1, 1'b0));
    apply(ctl("both_fs", 1'b1, 1'b0, 1'b0, 1'b0));
    apply(px("both_fade1", 12'h123, 12'h012));
    apply(ctl("both_fs2", 1'b1, 1'b0, 1'b0, 1'b0));
    apply(px("both_fade2", 12'h123, 12'h012));
    apply(ctl("both_clr", 1'b1, 1'b0, 1'b0, 1'b1));
    apply(px("both_idle", 12'h123, 12'h123));

    // In BLACK, fade_req and fade_clr together: clear wins.
    fade_run("fadeB");
    apply(ctl("fade_and_clr", 1'b1, 1'b0, 1'b1, 1'b1));
    apply(px("fc_idle", 12'hFDA, 12'hFDA));
    apply(ctl("fc_fs", 1'b1, 1'b0, 1'b0, 1'b0));
    apply(px("fc_idle2", 12'hFDA, 12'hFDA));
    busy_check("fc_busy", 1'b0);

    // Reset mid-FADE at level 5 (ninth frame after entry).
    for (int j = 1; j <= 9; j++) begin
      apply(ctl($sformatf("rst_fs%0d", j), 1'b1, 1'b0, (j == 1), 1'b0));
      apply(px($sformatf("rst_pix%0d", j), 12'hFDA, satsub(12'hFDA, 1 + (j - 1) / FADE_STEP_TB)));
    end
    apply(px("rst_lvl5_a", 12'hFDA, 12'hA85));
    apply(px("rst_lvl5_b", 12'hFDA, 12'hA85));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_rgb_valid", {valid_out, rgb_out}, 13'h0000);
    check("midreset_busy", {12'h000, fx_busy}, 13'h0000);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    apply(px("post_rst_a", 12'hFDA, 12'hFDA));
    apply(px("post_rst_b", 12'hFDA, 12'hFDA));
    apply(ctl("post_rst_fs", 1'b1, 1'b0, 1'b0, 1'b0));
    apply(px("post_rst_c", 12'hFDA, 12'hFDA));
    apply(ctl("final_drain0", 1'b0, 1'b0, 1'b0, 1'b0));
    apply(ctl("final_drain1", 1'b0, 1'b0, 1'b0, 1'b0));
    apply(ctl("final_drain2", 1'b0, 1'b0, 1'b0, 1'b0));
    busy_check("post_rst_busy", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
